// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction formats, opcodes and loader FSM states.
// The opcode values are shared with the control unit so producer and decoder agree.
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R      = 3'd0,
      FMT_I_ALU  = 3'd1,
      FMT_LOAD   = 3'd2,
      FMT_STORE  = 3'd3,
      FMT_BRANCH = 3'd4,
      FMT_JAL    = 3'd5,
      FMT_JALR   = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // True when imm is representable as a two's-complement value of 'width' bits.
   function automatic logic fits_signed(input logic [31:0] imm, input int unsigned width);
      logic [31:0] upper;
      upper = 32'($signed(imm) >>> (width - 32'd1));
      return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I field-to-word encoder with a legality flag for the
// immediate range / alignment and the format code.
module instr_encode
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   // Format-dependent bit packing and legality check.
   always_comb begin
      word  = 32'h0000_0000;
      legal = 1'b0;
      case (fmt)
         FMT_R: begin
            word  = {funct7, rs2, rs1, funct3, rd, OP_R};
            legal = 1'b1;
         end
         FMT_I_ALU: begin
            word  = {imm[11:0], rs1, funct3, rd, OP_IMM};
            legal = fits_signed(imm, 32'd12);
         end
         FMT_LOAD: begin
            word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            legal = fits_signed(imm, 32'd12);
         end
         FMT_JALR: begin
            word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            legal = fits_signed(imm, 32'd12);
         end
         FMT_STORE: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            legal = fits_signed(imm, 32'd12);
         end
         FMT_BRANCH: begin
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            legal = fits_signed(imm, 32'd13) && (imm[0] == 1'b0);
         end
         FMT_JAL: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            legal = fits_signed(imm, 32'd21) && (imm[0] == 1'b0);
         end
         default: begin
            word  = 32'h0000_0000;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields and writes the words sequentially into instruction
// memory, one word every two cycles, until last_i or the DEPTH cap ends the session.
module instr_encoder_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 256
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        fmt_i,
   input  logic              last_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [31:0]       imm_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic [ADDR_W-2:0] count_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W-2:0] CNT_LAST = (ADDR_W-1)'(DEPTH - 1);

   state_e            state_r, state_nx;
   logic [31:0]       word_s;
   logic              legal_s;
   logic              hs_s;
   logic              wr_end_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-2:0] count_r;
   logic [31:0]       word_r;
   logic              last_r, err_r;
   logic              ready_r, we_r, done_r;
   logic              ready_nx, we_nx, done_nx;

   instr_encode u_encode (
      .fmt    (fmt_i),
      .rd     (rd_i),
      .rs1    (rs1_i),
      .rs2    (rs2_i),
      .funct3 (funct3_i),
      .funct7 (funct7_i),
      .imm    (imm_i),
      .word   (word_s),
      .legal  (legal_s)
   );

   assign hs_s     = valid_i && (state_r == ST_ACCEPT);
   assign wr_end_s = last_r || (count_r == CNT_LAST);

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= ST_IDLE;
      else       state_r <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE:   if (start_i) state_nx = ST_ACCEPT; else state_nx = ST_IDLE;
         ST_ACCEPT: if (hs_s && legal_s) state_nx = ST_WRITE; else state_nx = ST_ACCEPT;
         ST_WRITE:  if (wr_end_s) state_nx = ST_DONE; else state_nx = ST_ACCEPT;
         ST_DONE:   if (start_i) state_nx = ST_ACCEPT; else state_nx = ST_DONE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the next state so they can be registered.
   always_comb begin
      ready_nx = 1'b0;
      we_nx    = 1'b0;
      done_nx  = 1'b0;
      case (state_nx)
         ST_ACCEPT: ready_nx = 1'b1;
         ST_WRITE:  we_nx    = 1'b1;
         ST_DONE:   done_nx  = 1'b1;
         default: begin
            ready_nx = 1'b0;
            we_nx    = 1'b0;
            done_nx  = 1'b0;
         end
      endcase
   end

   // Datapath: session counters, captured word and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_r  <= '0;
         count_r <= '0;
         word_r  <= 32'h0000_0000;
         last_r  <= 1'b0;
         err_r   <= 1'b0;
         ready_r <= 1'b0;
         we_r    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         ready_r <= ready_nx;
         we_r    <= we_nx;
         done_r  <= done_nx;
         if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start_i) begin
            addr_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
         end else if (hs_s) begin
            if (legal_s) begin
               word_r <= word_s;
               last_r <= last_i;
            end else begin
               err_r  <= 1'b1;
            end
         end else if (state_r == ST_WRITE) begin
            count_r <= count_r + (ADDR_W-1)'(1);
            if (!wr_end_s) addr_r <= addr_r + ADDR_W'(4);
         end
      end
   end

   // A reset arriving during the write cycle suppresses the strobe immediately.
   assign imem_we_o    = we_r & ~rst_i;
   assign ready_o      = ready_r;
   assign done_o       = done_r;
   assign err_o        = err_r;
   assign imem_addr_o  = addr_r;
   assign imem_wdata_o = word_r;
   assign count_o      = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: two instances, the default one and a
// DEPTH=4 one for the session-length cap.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst, start, valid, start4, valid4, last;
   logic [2:0]  fmt, f3;
   logic [4:0]  rd, rs1, rs2;
   logic [6:0]  f7;
   logic [31:0] imm;

   logic        ready, we, done, err, ready4, we4, done4, err4;
   logic [9:0]  addr, addr4;
   logic [31:0] wdata, wdata4;
   logic [8:0]  count, count4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(10), .DEPTH(256)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(ready),
      .fmt_i(fmt), .last_i(last), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
      .imem_we_o(we), .imem_addr_o(addr), .imem_wdata_o(wdata),
      .count_o(count), .done_o(done), .err_o(err)
   );

   instr_encoder_loader #(.ADDR_W(10), .DEPTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .valid_i(valid4), .ready_o(ready4),
      .fmt_i(fmt), .last_i(last), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
      .imem_we_o(we4), .imem_addr_o(addr4), .imem_wdata_o(wdata4),
      .count_o(count4), .done_o(done4), .err_o(err4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_session(input bit sel);
      if (sel) start4 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic set_fields(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                             input logic [31:0] im, input logic l);
      fmt = f; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im; last = l;
   endtask

   // Legal instruction: expect exactly one write strobe with the given address/word.
   task automatic send(input string tag, input bit sel, input logic [2:0] f, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic [31:0] im, input logic l,
                       input logic [9:0] exp_addr, input logic [31:0] exp_word);
      int n = 0;
      while (((sel ? ready4 : ready) !== 1'b1) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready"}, 32'(sel ? ready4 : ready), 32'd1);
      set_fields(f, d, s1, s2, fn3, fn7, im, l);
      if (sel) valid4 = 1'b1; else valid = 1'b1;
      @(posedge clk); #1;
      valid  = 1'b0;
      valid4 = 1'b0;
      check({tag, "_we"},   32'(sel ? we4 : we), 32'd1);
      check({tag, "_addr"}, 32'(sel ? addr4 : addr), 32'(exp_addr));
      check({tag, "_word"}, sel ? wdata4 : wdata, exp_word);
      @(posedge clk); #1;
      check({tag, "_we_once"}, 32'(sel ? we4 : we), 32'd0);
   endtask

   // Illegal instruction: no strobe, sticky error, address unchanged.
   task automatic send_bad(input string tag, input logic [2:0] f, input logic [31:0] im,
                           input logic [9:0] exp_addr);
      set_fields(f, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, im, 1'b0);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      check({tag, "_we"},    32'(we), 32'd0);
      check({tag, "_err"},   32'(err), 32'd1);
      check({tag, "_addr"},  32'(addr), 32'(exp_addr));
      check({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0; start4 = 1'b0; valid4 = 1'b0;
      set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_we",    32'(we),    32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_err",   32'(err),   32'd0);
      check("rst_addr",  32'(addr),  32'd0);
      check("rst_wdata", wdata,      32'd0);
      check("rst_count", 32'(count), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_ready", 32'(ready), 32'd0);

      // Session 1: I_ALU, R, STORE(last).
      start_session(1'b0);
      check("s1_ready", 32'(ready), 32'd1);
      check("s1_count", 32'(count), 32'd0);
      send("ialu",  1'b0, 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0, 10'h000, 32'h0050_0093);
      send("rtype", 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b0, 10'h004, 32'h0020_81B3);
      send("store", 1'b0, 3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1, 10'h008, 32'h0020_A423);
      check("s1_done",  32'(done),  32'd1);
      check("s1_cnt",   32'(count), 32'd3);
      check("s1_rdy0",  32'(ready), 32'd0);

      // Session 2: BRANCH, JAL, rejected words, then LOAD(last) at the held address.
      start_session(1'b0);
      check("s2_addr0", 32'(addr), 32'd0);
      send("branch", 1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b0, 10'h000, 32'h0000_0463);
      send("jal",    1'b0, 3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b0, 10'h004, 32'h0080_00EF);
      send_bad("bad_ialu2048", 3'd1, 32'd2048, 10'h008);
      send_bad("bad_br_odd",   3'd4, 32'd3,    10'h008);
      send_bad("bad_fmt7",     3'd7, 32'd0,    10'h008);
      send_bad("bad_jal_odd",  3'd5, 32'd1,    10'h008);
      send("load",   1'b0, 3'd2, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd4, 1'b1, 10'h008, 32'h0041_2283);
      check("s2_done",  32'(done),  32'd1);
      check("s2_cnt",   32'(count), 32'd3);
      check("s2_err",   32'(err),   32'd1);
      check("s2_rdy0",  32'(ready), 32'd0);

      // Session 3: immediate boundaries, JALR funct3 forcing.
      start_session(1'b0);
      check("s3_errclr", 32'(err), 32'd0);
      send("jalr",   1'b0, 3'd6, 5'd1, 5'd5, 5'd0, 3'b011, 7'd0, 32'hFFFF_FFFC, 1'b0, 10'h000, 32'hFFC2_80E7);
      send("imin",   1'b0, 3'd1, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800, 1'b0, 10'h004, 32'h8000_0013);
      send("jalneg", 1'b0, 3'd5, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFE, 1'b0, 10'h008, 32'hFFFF_F06F);
      send_bad("bad_st_lo", 3'd3, 32'hFFFF_F7FF, 10'h00C);

      // Reset while the write strobe is up.
      set_fields(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      check("rw_we_pre", 32'(we), 32'd1);
      rst = 1'b1;
      #1;
      check("rw_we_gated", 32'(we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rw_ready", 32'(ready), 32'd0);
      check("rw_we",    32'(we),    32'd0);
      check("rw_err",   32'(err),   32'd0);
      check("rw_done",  32'(done),  32'd0);
      check("rw_addr",  32'(addr),  32'd0);
      check("rw_wdata", wdata,      32'd0);
      check("rw_count", 32'(count), 32'd0);

      // DEPTH=4 cap without last_i.
      start_session(1'b1);
      send("d4_0", 1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b0, 10'h000, 32'h0010_0093);
      send("d4_1", 1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 1'b0, 10'h004, 32'h0020_0093);
      send("d4_2", 1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 1'b0, 10'h008, 32'h0030_0093);
      send("d4_3", 1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4, 1'b0, 10'h00C, 32'h0040_0093);
      check("d4_done",  32'(done4),  32'd1);
      check("d4_count", 32'(count4), 32'd4);
      check("d4_addr",  32'(addr4),  32'h00C);
      check("d4_ready", 32'(ready4), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
